// File: rtl/operand_uart_rx.sv
// UART receiver (8 data bits, LSB first) that pairs consecutive good bytes into operands a/b.
// Optional even-parity bit after the data bits when OPERAND_UART_RX_PARITY_EN is defined.
module operand_uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       pair_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = 12;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef OPERAND_UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t         state_q, state_d;
    logic           rx_meta_q, rx_meta_d;
    logic           rx_s_q, rx_s_d;
    logic [1:0]     sync_vld_q, sync_vld_d;
    logic           armed_q, armed_d;
    logic [CW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           idx_q, idx_d;
    logic [7:0]     hold_q, hold_d;
    logic [7:0]     a_q, a_d;
    logic [7:0]     b_q, b_d;
    logic           pair_valid_q, pair_valid_d;
    logic           frame_err_q, frame_err_d;
    logic           busy_q, busy_d;
`ifdef OPERAND_UART_RX_PARITY_EN
    logic           parity_err_q, parity_err_d;
`endif
    logic           tick;
    logic           stop_ok;

    assign a          = a_q;
    assign b          = b_q;
    assign pair_valid = pair_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

    always_comb begin
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        sync_vld_d   = {sync_vld_q[0], 1'b1};
        state_d      = state_q;
        armed_d      = armed_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        a_d          = a_q;
        b_d          = b_q;
        pair_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef OPERAND_UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        tick    = (state_q == START) ? (baud_q == HALF_M1) : (baud_q == FULL_M1);
        stop_ok = rx_s_q;
`ifdef OPERAND_UART_RX_PARITY_EN
        stop_ok = rx_s_q & ~parity_err_q;
`endif
        if (state_q != IDLE)
            baud_d = tick ? '0 : baud_q + 1'b1;

        case (state_q)
            IDLE: begin
                // Only arm on a high level that came through the synchronizer,
                // not the reset value of its flops.
                armed_d = armed_q | (rx_s_q & sync_vld_q[1]);
                if (armed_q && !rx_s_q) begin
                    state_d = START;
                    armed_d = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
`ifdef OPERAND_UART_RX_PARITY_EN
                    parity_err_d = 1'b0;
`endif
                end
            end
            START: begin
                if (tick)
                    state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d[bit_q] = rx_s_q;
                    if (bit_q == 3'd7) begin
`ifdef OPERAND_UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef OPERAND_UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    parity_err_d = rx_s_q ^ (^shift_q);
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    // A low stop bit leaves the line low; wait for it to go high again.
                    armed_d = rx_s_q;
                    if (stop_ok) begin
                        if (!idx_q) begin
                            hold_d = shift_q;
                            idx_d  = 1'b1;
                        end else begin
                            a_d          = hold_q;
                            b_d          = shift_q;
                            pair_valid_d = 1'b1;
                            idx_d        = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        idx_d       = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            sync_vld_q   <= '0;
            armed_q      <= 1'b0;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            idx_q        <= 1'b0;
            hold_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            pair_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef OPERAND_UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            sync_vld_q   <= sync_vld_d;
            armed_q      <= armed_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            a_q          <= a_d;
            b_q          <= b_d;
            pair_valid_q <= pair_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef OPERAND_UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_operand_uart_rx.sv
// Self-checking bench for operand_uart_rx: directed scenarios plus random frames vs. a pairing model.
module tb_operand_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] a, b;
    logic       pair_valid, frame_err, busy;

    operand_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .a(a), .b(b),
        .pair_valid(pair_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observed events
    logic [15:0] pv_q[$];
    int          fe_cnt = 0;
    int          both_cnt = 0;
    int          chg_err = 0;
    bit          busy_seen = 1'b0;
    logic [7:0]  a_prev = 8'h00, b_prev = 8'h00;
    bit          rst_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pair_valid) pv_q.push_back({a, b});
            if (frame_err) fe_cnt++;
            if (pair_valid && frame_err) both_cnt++;
            if (busy) busy_seen = 1'b1;
            if (rst_prev && !pair_valid && (a !== a_prev || b !== b_prev)) chg_err++;
        end
        a_prev   = a;
        b_prev   = b;
        rst_prev = rst_n;
    end

    // Reference model: byte stream -> operand pairs
    logic [15:0] exp_q[$];
    int          fe_exp = 0;
    bit          m_idx = 1'b0;
    logic [7:0]  m_hold = 8'h00, m_a = 8'h00, m_b = 8'h00;

    task automatic model_byte(input logic [7:0] d, input bit good);
        if (!good) begin
            fe_exp++;
            m_idx = 1'b0;
        end else if (!m_idx) begin
            m_hold = d;
            m_idx  = 1'b1;
        end else begin
            m_a = m_hold;
            m_b = d;
            exp_q.push_back({m_a, m_b});
            m_idx = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_idx = 1'b0; m_hold = 8'h00; m_a = 8'h00; m_b = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_phase(input string tag);
        chk({tag, "_npairs"}, pv_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < pv_q.size()) chk({tag, "_pair"}, pv_q[i], exp_q[i]);
        chk({tag, "_ferr"}, fe_cnt, fe_exp);
        chk({tag, "_a"}, a, m_a);
        chk({tag, "_b"}, b, m_b);
        pv_q.delete();
        exp_q.delete();
        fe_cnt = 0;
        fe_exp = 0;
    endtask

    // All line drive happens 1ns after a rising edge.
    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop_bit, input bit par_flip);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef OPERAND_UART_RX_PARITY_EN
        bit_time((^d) ^ par_flip);
`endif
        bit_time(stop_bit);
        model_byte(d, stop_bit && !par_flip);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a"}, a, 8'h00);
        chk({tag, "_b"}, b, 8'h00);
        chk({tag, "_pv"}, pair_valid, 1'b0);
        chk({tag, "_fe"}, frame_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] rst_byte;
        bit         bad_stop;
        bit         pf;
        int         gap;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        idle(CPB);

        // Basic pair
        send(8'h3C, 1'b1, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        idle(CPB);
        chk_phase("basic");

        // Bad stop bit discards the byte and restarts pairing
        send(8'h11, 1'b0, 1'b0);
        idle(CPB);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        idle(CPB);
        chk_phase("stop_err");

        // Pending A dropped by a frame error
        send(8'h44, 1'b1, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        idle(CPB);
        send(8'h66, 1'b1, 1'b0);
        send(8'h77, 1'b1, 1'b0);
        idle(CPB);
        chk_phase("drop_a");

        // Short low glitch on idle line
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(2 * CPB);
        chk("glitch_busy_seen", busy_seen, 1'b1);
        chk("glitch_busy_now", busy, 1'b0);
        chk_phase("glitch");

        // Reset in the middle of bit 4 of the second byte, line held low through release
        send(8'h01, 1'b1, 1'b0);
        rst_byte = 8'h02;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(rst_byte[i]);
        rx = rst_byte[4];
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        model_reset();
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_seen = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1;
        chk("low_after_rst_no_start", busy_seen, 1'b0);
        idle(CPB);
        send(8'h07, 1'b1, 1'b0);
        send(8'h08, 1'b1, 1'b0);
        idle(CPB);
        chk_phase("after_rst");

        // Back-to-back frames, no idle between them
        send(8'hFF, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h80, 1'b1, 1'b0);
        send(8'h01, 1'b1, 1'b0);
        idle(CPB);
        chk_phase("b2b");

`ifdef OPERAND_UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        idle(CPB);
        send(8'h07, 1'b1, 1'b0);
        send(8'h09, 1'b1, 1'b0);
        idle(CPB);
        chk_phase("parity");
`endif

        // Random byte stream with occasional bad frames and variable gaps
        for (int n = 0; n < 16; n++) begin
            d        = 8'($urandom);
            bad_stop = ($urandom_range(0, 4) == 0);
            pf       = 1'b0;
`ifdef OPERAND_UART_RX_PARITY_EN
            pf       = ($urandom_range(0, 5) == 0);
`endif
            send(d, !bad_stop, pf);
            gap = bad_stop ? $urandom_range(1, 2) : $urandom_range(0, 2);
            idle(gap * CPB);
        end
        idle(CPB);
        chk_phase("random");

        chk("never_both_flags", both_cnt, 0);
        chk("ab_change_only_with_pv", chg_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
